// File: rtl/bemf_pkg.sv
// Shared types and constants for the back-EMF measurement scheduler.
package bemf_pkg;

    localparam int unsigned NUM_MOT     = 4;
    localparam int unsigned DEF_ADC_W   = 10;
    localparam int unsigned DEF_PERIOD  = 832000;
    localparam int unsigned DEF_SETTLE  = 2600;
    localparam int unsigned DEF_TIMEOUT = 1023;

    // Bits needed to hold the values 0..max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int unsigned DEF_PER_W = cnt_w(DEF_PERIOD - 1);
    localparam int unsigned DEF_SET_W = cnt_w(DEF_SETTLE);
    localparam int unsigned DEF_TMO_W = cnt_w(DEF_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StWait,
        StGap,
        StDone
    } bemf_state_e;

endpackage

// File: rtl/bemf_adc_xfer.sv
// One ADC request/acknowledge transfer with a per-request timeout.
module bemf_adc_xfer import bemf_pkg::*; #(
    parameter int unsigned ADC_W   = DEF_ADC_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort_i,
    input  logic             start_i,
    input  logic             adc_ack_i,
    input  logic [ADC_W-1:0] adc_data_i,
    output logic             adc_req_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [ADC_W-1:0] data_o
);

    localparam int unsigned TMO_W = cnt_w(TIMEOUT);

    logic             req_q, req_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ack_hit, tmo_hit;

    always_comb begin
        ack_hit = req_q & adc_ack_i;
        // An ack arriving on the final allowed cycle still wins over the timeout.
        tmo_hit = req_q & ~adc_ack_i & (tmo_q == TMO_W'(TIMEOUT - 1));
        req_d   = req_q;
        tmo_d   = req_q ? tmo_q + 1'b1 : '0;
        if (abort_i) begin
            req_d = 1'b0;
        end else if (start_i) begin
            req_d = 1'b1;
            tmo_d = '0;
        end else if (ack_hit | tmo_hit) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            req_q <= req_d;
            tmo_q <= tmo_d;
        end
    end

    assign adc_req_o = req_q;
    assign done_o    = ack_hit | tmo_hit;
    assign timeout_o = tmo_hit;
    assign data_o    = adc_data_i;

endmodule

// File: rtl/bemf_scheduler.sv
// Periodic back-EMF measurement sequencer for four motors sharing one ADC.
// Define BEMF_AVG_EN to take and average two conversions per motor.
module bemf_scheduler import bemf_pkg::*; #(
    parameter int unsigned PERIOD  = DEF_PERIOD,
    parameter int unsigned SETTLE  = DEF_SETTLE,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned ADC_W   = DEF_ADC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mot_en_i,
    input  logic             adc_ack_i,
    input  logic [ADC_W-1:0] adc_data_i,
    output logic             bemf_sensing_o,
    output logic             adc_req_o,
    output logic [1:0]       adc_chan_o,
    output logic [ADC_W-1:0] bemf0_o,
    output logic [ADC_W-1:0] bemf1_o,
    output logic [ADC_W-1:0] bemf2_o,
    output logic [ADC_W-1:0] bemf3_o,
    output logic             bemf_valid_o,
    output logic [3:0]       timeout_err_o,
    output logic             overrun_o
);

    localparam int unsigned PER_W = cnt_w(PERIOD - 1);
    localparam int unsigned SET_W = cnt_w(SETTLE);

    bemf_state_e          state_q, state_d;
    logic [PER_W-1:0]     per_q, per_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [1:0]           chan_q, chan_d;
    logic [NUM_MOT-1:0]   err_q, err_d, terr_q, terr_d;
    logic [ADC_W-1:0]     bemf_q [NUM_MOT];
    logic [ADC_W-1:0]     bemf_d [NUM_MOT];
    logic                 sensing_q, sensing_d, valid_q, valid_d, overrun_q, overrun_d;
    logic                 tick, last_smp;
    logic                 xfer_start, xfer_done, xfer_tmo;
    logic [ADC_W-1:0]     xfer_data;
`ifdef BEMF_AVG_EN
    logic                 smp_q, smp_d;
    logic [ADC_W-1:0]     acc_q, acc_d;
    logic [ADC_W:0]       sum;
`endif

    bemf_adc_xfer #(
        .ADC_W   (ADC_W),
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort_i    (~mot_en_i),
        .start_i    (xfer_start),
        .adc_ack_i  (adc_ack_i),
        .adc_data_i (adc_data_i),
        .adc_req_o  (adc_req_o),
        .done_o     (xfer_done),
        .timeout_o  (xfer_tmo),
        .data_o     (xfer_data)
    );

    always_comb begin
        tick  = mot_en_i & (per_q == PER_W'(PERIOD - 1));
        per_d = (!mot_en_i || tick) ? '0 : per_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        set_d      = set_q;
        chan_d     = chan_q;
        err_d      = err_q;
        terr_d     = terr_q;
        bemf_d     = bemf_q;
        xfer_start = 1'b0;
        last_smp   = 1'b1;
`ifdef BEMF_AVG_EN
        smp_d      = smp_q;
        acc_d      = acc_q;
        sum        = {1'b0, acc_q} + {1'b0, xfer_data};
`endif
        if (!mot_en_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (tick) begin
                    state_d = StSettle;
                    set_d   = SET_W'(SETTLE - 1);
                    err_d   = '0;
                    chan_d  = 2'd0;
`ifdef BEMF_AVG_EN
                    smp_d   = 1'b0;
`endif
                end
                StSettle: begin
                    if (set_q == '0) begin
                        state_d    = StWait;
                        xfer_start = 1'b1;
                    end else begin
                        set_d = set_q - 1'b1;
                    end
                end
                StWait: if (xfer_done) begin
`ifdef BEMF_AVG_EN
                    if (!smp_q) begin
                        acc_d    = xfer_data;
                        smp_d    = 1'b1;
                        last_smp = 1'b0;
                    end else begin
                        smp_d = 1'b0;
                        if (!xfer_tmo && !err_q[chan_q]) bemf_d[chan_q] = sum[ADC_W:1];
                    end
`else
                    if (!xfer_tmo) bemf_d[chan_q] = xfer_data;
`endif
                    if (xfer_tmo) err_d[chan_q] = 1'b1;
                    if (last_smp && chan_q == 2'd3) begin
                        state_d = StDone;
                        terr_d  = err_d;
                    end else begin
                        state_d = StGap;
                    end
                end
                StGap: begin
                    state_d    = StWait;
                    xfer_start = 1'b1;
`ifdef BEMF_AVG_EN
                    chan_d     = smp_q ? chan_q : chan_q + 2'd1;
`else
                    chan_d     = chan_q + 2'd1;
`endif
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        sensing_d = (state_d == StSettle) || (state_d == StWait) || (state_d == StGap);
        valid_d   = (state_d == StDone);
        overrun_d = tick & (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q     <= '0;
            set_q     <= '0;
            chan_q    <= 2'd0;
            err_q     <= '0;
            terr_q    <= '0;
            bemf_q    <= '{default: '0};
            sensing_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef BEMF_AVG_EN
            smp_q     <= 1'b0;
            acc_q     <= '0;
`endif
        end else begin
            per_q     <= per_d;
            set_q     <= set_d;
            chan_q    <= chan_d;
            err_q     <= err_d;
            terr_q    <= terr_d;
            bemf_q    <= bemf_d;
            sensing_q <= sensing_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef BEMF_AVG_EN
            smp_q     <= smp_d;
            acc_q     <= acc_d;
`endif
        end
    end

    assign bemf_sensing_o = sensing_q;
    assign adc_chan_o     = chan_q;
    assign bemf0_o        = bemf_q[0];
    assign bemf1_o        = bemf_q[1];
    assign bemf2_o        = bemf_q[2];
    assign bemf3_o        = bemf_q[3];
    assign bemf_valid_o   = valid_q;
    assign timeout_err_o  = terr_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_bemf_scheduler.sv
// Directed bench for bemf_scheduler: a main instance (PERIOD=200) and a fast one (PERIOD=20).
`timescale 1ns/1ps
module tb_bemf_scheduler;

    localparam int unsigned ADC_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, mot_en, adc_ack, bemf_sensing, adc_req, bemf_valid, overrun;
    logic [ADC_W-1:0] adc_data, bemf0, bemf1, bemf2, bemf3;
    logic [1:0]       adc_chan;
    logic [3:0]       timeout_err;

    logic             mot_en_f, adc_ack_f, sens_f, req_f, valid_f, ovr_f;
    logic [ADC_W-1:0] adc_data_f, b0_f, b1_f, b2_f, b3_f;
    logic [1:0]       chan_f;
    logic [3:0]       terr_f;

    bemf_scheduler #(.PERIOD(200), .SETTLE(10), .TIMEOUT(8), .ADC_W(ADC_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .mot_en_i(mot_en), .adc_ack_i(adc_ack),
        .adc_data_i(adc_data), .bemf_sensing_o(bemf_sensing), .adc_req_o(adc_req),
        .adc_chan_o(adc_chan), .bemf0_o(bemf0), .bemf1_o(bemf1), .bemf2_o(bemf2),
        .bemf3_o(bemf3), .bemf_valid_o(bemf_valid), .timeout_err_o(timeout_err),
        .overrun_o(overrun)
    );

    bemf_scheduler #(.PERIOD(20), .SETTLE(10), .TIMEOUT(16), .ADC_W(ADC_W)) u_dut_fast (
        .clk(clk), .rst_n(rst_n), .mot_en_i(mot_en_f), .adc_ack_i(adc_ack_f),
        .adc_data_i(adc_data_f), .bemf_sensing_o(sens_f), .adc_req_o(req_f),
        .adc_chan_o(chan_f), .bemf0_o(b0_f), .bemf1_o(b1_f), .bemf2_o(b2_f),
        .bemf3_o(b3_f), .bemf_valid_o(valid_f), .timeout_err_o(terr_f),
        .overrun_o(ovr_f)
    );

    int               checks = 0;
    int               errors = 0;
    int               ack_dly = 3;
    int               nack_chan = 99;
    bit               avg_mode = 1'b0;
    int               req_seen = 0;
    int               rsp_cnt = 0;
    int               rsp_cnt_f = 0;
    logic [ADC_W-1:0] data_base = '0;

    // Per-set observations filled by run_set
    int               s_rises, s_min_gap, s_sens_len, s_vcount, s_chan2_hi;
    bit               s_order_ok, s_tmo;
    logic             s_valid_fall;
    logic [3:0]       s_terr;

    // ADC model for the main instance: acks ack_dly cycles after req rises.
    initial begin
        adc_ack  = 1'b0;
        adc_data = '0;
        forever begin
            @(posedge clk); #1;
            if (adc_req) rsp_cnt++; else rsp_cnt = 0;
            if (rsp_cnt == 1) begin
                if (avg_mode) adc_data = (req_seen % 2 == 0) ? 10'h3FF : 10'h001;
                else          adc_data = data_base + ADC_W'(adc_chan);
                req_seen++;
            end
            adc_ack = adc_req && (rsp_cnt == ack_dly) && (int'(adc_chan) != nack_chan);
        end
    end

    // Slow ADC model for the fast instance: ack after 10 cycles.
    initial begin
        adc_ack_f  = 1'b0;
        adc_data_f = 10'h055;
        forever begin
            @(posedge clk); #1;
            if (req_f) rsp_cnt_f++; else rsp_cnt_f = 0;
            adc_ack_f = req_f && (rsp_cnt_f == 10);
        end
    end

    task automatic wait_rise(input int bound, output int n, output bit tmo);
        logic prev;
        prev = bemf_sensing;
        n    = 0;
        tmo  = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            n++;
            if (bemf_sensing && !prev) begin
                tmo = 1'b0;
                break;
            end
            prev = bemf_sensing;
        end
    endtask

    // Called on the sample where bemf_sensing has just risen; follows the set to its end.
    task automatic run_set();
        logic prev_req;
        int   low, expch;
        s_rises = 0; s_min_gap = 1000; s_sens_len = 1; s_vcount = 0; s_chan2_hi = 0;
        s_order_ok = 1'b1; s_tmo = 1'b1; s_valid_fall = 1'b0; s_terr = '0;
        prev_req = adc_req;
        low = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (!bemf_sensing) begin
                s_valid_fall = bemf_valid;
                s_terr       = timeout_err;
                s_tmo        = 1'b0;
                break;
            end
            s_sens_len++;
            if (adc_req) begin
                if (!prev_req) begin
                    if (s_rises > 0 && low < s_min_gap) s_min_gap = low;
                    expch = avg_mode ? (s_rises / 2) % 4 : s_rises % 4;
                    if (int'(adc_chan) != expch) s_order_ok = 1'b0;
                    s_rises++;
                end
                if (adc_chan == 2'd2) s_chan2_hi++;
                low = 0;
            end else begin
                low++;
            end
            prev_req = adc_req;
        end
        s_vcount = int'(s_valid_fall);
        repeat (5) begin
            @(posedge clk); #1;
            if (bemf_valid) s_vcount++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mot_en = 1'b0; mot_en_f = 1'b0;
        #2;
        checks++;
        if ({bemf_sensing, adc_req, adc_chan, bemf_valid, overrun, timeout_err,
             bemf0, bemf1, bemf2, bemf3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: sens=%b req=%b chan=%0d valid=%b ovr=%b terr=%b required all 0",
                     bemf_sensing, adc_req, adc_chan, bemf_valid, overrun, timeout_err);
        end
        mot_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bemf_sensing, adc_req, bemf_valid, sens_f} !== 4'b0) begin
            errors++;
            $display("FAIL reset_held: sens=%b req=%b valid=%b required 0", bemf_sensing,
                     adc_req, bemf_valid);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        int n;
        bit tmo;
        data_base = 10'h100;
        wait_rise(400, n, tmo);
        checks++;
        if (tmo || n != 200) begin
            errors++;
            $display("FAIL first_tick: got %0d cycles (timeout=%b) required 200", n, tmo);
        end
        run_set();
        checks++;
        if (s_tmo) begin errors++; $display("FAIL normal_end: set never ended"); end
        checks++;
        if (s_rises != 4) begin
            errors++; $display("FAIL normal_reqs: got %0d required 4", s_rises);
        end
        checks++;
        if (s_min_gap != 1 || !s_order_ok) begin
            errors++; $display("FAIL normal_gap_order: gap %0d order_ok %b required 1 1",
                               s_min_gap, s_order_ok);
        end
        checks++;
        if (s_sens_len != 25) begin
            errors++; $display("FAIL normal_sense_len: got %0d required 25", s_sens_len);
        end
        checks++;
        if (s_valid_fall !== 1'b1 || s_vcount != 1) begin
            errors++; $display("FAIL normal_valid: at_fall %b pulses %0d required 1 1",
                               s_valid_fall, s_vcount);
        end
        checks++;
        if (s_terr !== 4'b0000) begin
            errors++; $display("FAIL normal_terr: got %b required 0000", s_terr);
        end
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {10'h103, 10'h102, 10'h101, 10'h100}) begin
            errors++; $display("FAIL normal_bemf: got %h %h %h %h required 100 101 102 103",
                               bemf0, bemf1, bemf2, bemf3);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit tmo;
        data_base = 10'h200;
        nack_chan = 2;
        wait_rise(400, n, tmo);
        checks++;
        if (tmo || n != 170) begin
            errors++; $display("FAIL period: got %0d cycles (timeout=%b) required 170", n, tmo);
        end
        run_set();
        nack_chan = 99;
        checks++;
        if (s_chan2_hi != 8) begin
            errors++; $display("FAIL tmo_req_len: got %0d required 8", s_chan2_hi);
        end
        checks++;
        if (s_sens_len != 30) begin
            errors++; $display("FAIL tmo_sense_len: got %0d required 30", s_sens_len);
        end
        checks++;
        if (s_valid_fall !== 1'b1 || s_terr !== 4'b0100) begin
            errors++; $display("FAIL tmo_terr: valid %b terr %b required 1 0100",
                               s_valid_fall, s_terr);
        end
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {10'h203, 10'h102, 10'h201, 10'h200}) begin
            errors++; $display("FAIL tmo_bemf: got %h %h %h %h required 200 201 102 203",
                               bemf0, bemf1, bemf2, bemf3);
        end
    endtask

    task automatic test_mot_drop();
        int n, vcnt;
        bit tmo, found;
        data_base = 10'h300;
        wait_rise(400, n, tmo);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (adc_req && adc_chan == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (tmo || !found) begin
            errors++; $display("FAIL drop_reach_chan1: rise_tmo %b found %b required 0 1", tmo, found);
        end
        mot_en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({adc_req, bemf_sensing, bemf_valid} !== 3'b000) begin
            errors++; $display("FAIL drop_idle: req %b sens %b valid %b required 000",
                               adc_req, bemf_sensing, bemf_valid);
        end
        vcnt = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bemf_valid) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            errors++; $display("FAIL drop_no_valid: got %0d pulses required 0", vcnt);
        end
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {10'h203, 10'h102, 10'h201, 10'h300} ||
            timeout_err !== 4'b0100) begin
            errors++; $display("FAIL drop_retain: got %h %h %h %h terr %b required 300 201 102 203 0100",
                               bemf0, bemf1, bemf2, bemf3, timeout_err);
        end
        mot_en = 1'b1;
        wait_rise(400, n, tmo);
        checks++;
        if (tmo || n != 200) begin
            errors++; $display("FAIL drop_restart: got %0d cycles required 200", n);
        end
        run_set();
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {10'h303, 10'h302, 10'h301, 10'h300} ||
            s_terr !== 4'b0000 || s_valid_fall !== 1'b1) begin
            errors++; $display("FAIL drop_resume: got %h %h %h %h terr %b valid %b",
                               bemf0, bemf1, bemf2, bemf3, s_terr, s_valid_fall);
        end
    endtask

    task automatic test_async_reset();
        int n;
        bit tmo, found;
        data_base = 10'h080;
        wait_rise(400, n, tmo);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (adc_req) begin
                found = 1'b1;
                break;
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {bemf_sensing, adc_req, adc_chan, bemf_valid, overrun, timeout_err,
                       bemf0, bemf1, bemf2, bemf3} !== '0) begin
            errors++; $display("FAIL async_reset: found %b sens %b req %b bemf0 %h terr %b required 1 0 0 0 0",
                               found, bemf_sensing, adc_req, bemf0, timeout_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_rise(400, n, tmo);
        checks++;
        if (tmo || n != 200) begin
            errors++; $display("FAIL rst_restart: got %0d cycles required 200", n);
        end
        run_set();
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {10'h083, 10'h082, 10'h081, 10'h080} ||
            s_valid_fall !== 1'b1) begin
            errors++; $display("FAIL rst_resume: got %h %h %h %h valid %b required 080 081 082 083 1",
                               bemf0, bemf1, bemf2, bemf3, s_valid_fall);
        end
    endtask

    task automatic test_overrun();
        int  n, ovr, run, max_run;
        logic prev;
        bit   got;
        @(posedge clk); #1;
        mot_en_f = 1'b1;
        n = 0; got = 1'b0; prev = sens_f;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (sens_f && !prev) begin got = 1'b1; break; end
            prev = sens_f;
        end
        checks++;
        if (!got || n != 20) begin
            errors++; $display("FAIL fast_first_tick: got %0d found %b required 20", n, got);
        end
        n = 0; ovr = 0; run = 0; max_run = 0; got = 1'b0; prev = sens_f;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (ovr_f) begin
                ovr++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (sens_f && !prev) begin got = 1'b1; break; end
            prev = sens_f;
        end
        checks++;
        if (!got || n != 60) begin
            errors++; $display("FAIL fast_next_set: got %0d found %b required 60", n, got);
        end
        checks++;
        if (ovr != 2 || max_run != 1) begin
            errors++; $display("FAIL overrun: got %0d pulses max width %0d required 2 1", ovr, max_run);
        end
        mot_en_f = 1'b0;
    endtask

    task automatic test_avg();
        int n;
        bit tmo;
        avg_mode = 1'b1;
        req_seen = 0;
        wait_rise(400, n, tmo);
        checks++;
        if (tmo) begin errors++; $display("FAIL avg_start: no set started"); end
        run_set();
        checks++;
        if (s_rises != 8 || !s_order_ok || s_min_gap != 1) begin
            errors++; $display("FAIL avg_reqs: got %0d order %b gap %0d required 8 1 1",
                               s_rises, s_order_ok, s_min_gap);
        end
        checks++;
        if ({bemf3, bemf2, bemf1, bemf0} !== {4{10'h200}} || s_terr !== 4'b0000) begin
            errors++; $display("FAIL avg_bemf: got %h %h %h %h terr %b required 200 x4 0000",
                               bemf0, bemf1, bemf2, bemf3, s_terr);
        end
    endtask

    initial begin
        test_reset();
`ifdef BEMF_AVG_EN
        test_avg();
`else
        test_normal();
        test_timeout();
        test_mot_drop();
        test_async_reset();
        test_overrun();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
